// File: rtl/rx78_pkg.sv
`default_nettype none
// ============================================================================
// Module : rx78_pkg
// Brief  : Shared types and constants for the rx78 ioctl upload/download paths.
// Rev    : 1.0  initial release
// ============================================================================
package rx78_pkg;

  typedef enum logic [1:0] {
    UP_IDLE = 2'd0,
    UP_REQ  = 2'd1,
    UP_LAT  = 2'd2
  } up_state_t;

  localparam int         IOCTL_AW   = 25;
  localparam logic [7:0] CART_INDEX = 8'd1;

endpackage
`default_nettype wire

// File: rtl/rx78_ioctl_upload.sv
`default_nettype none
// ============================================================================
// Module : rx78_ioctl_upload
// Brief  : Serves HPS ioctl upload byte reads from cartridge/work BRAM.
// Rev    : 1.0  initial release
// ============================================================================
module rx78_ioctl_upload
  import rx78_pkg::*;
#(
  parameter int         ADDR_W     = 15,
  parameter int         SIZE       = 32768,
  parameter logic [7:0] INDEX      = CART_INDEX,
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] FILL       = 8'hFF
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic                busy,
  output logic                upload_done,
  output logic [IOCTL_AW-1:0] byte_count
);

  localparam logic [IOCTL_AW-1:0] c_size     = IOCTL_AW'(SIZE);
  localparam logic [1:0]          c_lat_init = 2'(RD_LATENCY - 1);

  up_state_t   r_state;
  up_state_t   w_next;
  logic [1:0]  r_lat_cnt;
  logic        r_upload_q;

  logic w_index_ok;
  logic w_in_range;
  logic w_hit;
  logic w_start;
  logic w_fill;
  logic w_capture;
  logic w_rise;
  logic w_fall;
  logic w_inc;

  assign w_index_ok = (ioctl_index == INDEX);
  assign w_in_range = (ioctl_addr < c_size);
  assign w_hit      = ioctl_upload & w_index_ok & ioctl_rd;
  assign w_start    = (r_state == UP_IDLE) & w_hit & w_in_range;
  assign w_fill     = (r_state == UP_IDLE) & w_hit & ~w_in_range;
  assign w_capture  = (r_state == UP_LAT) & ioctl_upload & (r_lat_cnt == 2'd0);
  assign w_rise     = ioctl_upload & ~r_upload_q & w_index_ok;
  assign w_fall     = ~ioctl_upload & r_upload_q & w_index_ok;
  assign w_inc      = w_fill | w_capture;

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= UP_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a dropped session aborts any read in flight
  always_comb begin
    w_next = r_state;
    case (r_state)
      UP_IDLE: if (w_start) w_next = UP_REQ;
      UP_REQ: begin
        if (!ioctl_upload) w_next = UP_IDLE;
        else if (mem_gnt)  w_next = UP_LAT;
      end
      UP_LAT: begin
        if (!ioctl_upload || r_lat_cnt == 2'd0) w_next = UP_IDLE;
      end
      default: w_next = UP_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req    = (r_state == UP_REQ);
    busy       = (r_state != UP_IDLE);
    ioctl_wait = (r_state != UP_IDLE) | (w_hit & w_in_range);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_lat_cnt   <= 2'd0;
      r_upload_q  <= 1'b0;
      mem_addr    <= '0;
      ioctl_din   <= 8'h00;
      byte_count  <= '0;
      upload_done <= 1'b0;
    end else begin
      r_upload_q  <= ioctl_upload;
      upload_done <= w_fall;

      if (w_start) mem_addr <= ioctl_addr[ADDR_W-1:0];

      if (r_state == UP_REQ && mem_gnt)
        r_lat_cnt <= c_lat_init;
      else if (r_state == UP_LAT && r_lat_cnt != 2'd0)
        r_lat_cnt <= r_lat_cnt - 2'd1;

      if (w_fill)         ioctl_din <= FILL;
      else if (w_capture) ioctl_din <= mem_rdata;

      // A read landing on the session's first cycle counts after the clear
      if (w_rise)     byte_count <= IOCTL_AW'(w_inc);
      else if (w_inc) byte_count <= byte_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx78_ioctl_upload.sv
`default_nettype none
// ============================================================================
// Module : tb_rx78_ioctl_upload
// Brief  : Directed self-checking bench for rx78_ioctl_upload.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rx78_ioctl_upload;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        mem_gnt;

  logic [7:0]  ioctl_din,  ioctl_din3;
  logic        ioctl_wait, ioctl_wait3;
  logic        mem_req,    mem_req3;
  logic [14:0] mem_addr,   mem_addr3;
  logic [7:0]  mem_rdata,  mem_rdata3;
  logic        busy,       busy3;
  logic        upload_done, upload_done3;
  logic [24:0] byte_count, byte_count3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:255];
  logic [7:0] p1_0, p3_0, p3_1, p3_2;

  always #5 clk_sys = ~clk_sys;

  // BRAM models: one-cycle and three-cycle read pipelines
  always @(posedge clk_sys) begin
    p1_0 <= mem[mem_addr[7:0]];
    p3_0 <= mem[mem_addr3[7:0]];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign mem_rdata  = p1_0;
  assign mem_rdata3 = p3_2;

  rx78_ioctl_upload #(.ADDR_W(15), .SIZE(32768), .INDEX(8'd1), .RD_LATENCY(1), .FILL(8'hFF)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .upload_done(upload_done), .byte_count(byte_count)
  );

  rx78_ioctl_upload #(.ADDR_W(15), .SIZE(32768), .INDEX(8'd1), .RD_LATENCY(3), .FILL(8'hFF)) dut3 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din3), .ioctl_wait(ioctl_wait3),
    .mem_req(mem_req3), .mem_gnt(mem_gnt), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
    .busy(busy3), .upload_done(upload_done3), .byte_count(byte_count3)
  );

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  // Counts wait-high cycles from the current one, dropping ioctl_rd after the first
  task automatic count_wait(input bit sel, output int n);
    n = 0;
    while (((sel ? ioctl_wait3 : ioctl_wait) === 1'b1) && n < 40) begin
      n++;
      @(posedge clk_sys);
      #1;
      ioctl_rd = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = '0; mem_gnt = 1'b0;
    step; #1;
    checks++; if (ioctl_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", ioctl_din); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 15'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if (busy !== 1'b0 || upload_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, upload_done); end
    checks++; if (byte_count !== 25'd0) begin errors++; $display("FAIL reset_count got %0d want 0", byte_count); end
    reset = 1'b0;
    step;
  endtask

  task automatic test_basic;
    int n;
    ioctl_upload = 1'b1; ioctl_index = 8'd1; mem_gnt = 1'b1;
    step;
    ioctl_rd = 1'b1; ioctl_addr = 25'h10; #1;
    count_wait(1'b0, n);
    checks++; if (n != 3) begin errors++; $display("FAIL basic_wait_cycles got %0d want 3", n); end
    checks++; if (ioctl_din !== 8'h5A) begin errors++; $display("FAIL basic_din got %h want 5a", ioctl_din); end
    checks++; if (byte_count !== 25'd1) begin errors++; $display("FAIL basic_count got %0d want 1", byte_count); end
  endtask

  task automatic test_gnt_stall;
    int n, m;
    mem_gnt = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h20; #1;
    n = 1;
    for (int i = 0; i < 5; i++) begin
      step; ioctl_rd = 1'b0; #1;
      n++;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 15'h20 || ioctl_wait !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got req=%b addr=%h wait=%b want 1/0020/1", i, mem_req, mem_addr, ioctl_wait);
      end
    end
    step; mem_gnt = 1'b1; #1;
    count_wait(1'b0, m);
    checks++; if (n + m != 8) begin errors++; $display("FAIL stall_wait_cycles got %0d want 8", n + m); end
    checks++; if (ioctl_din !== 8'hA5) begin errors++; $display("FAIL stall_din got %h want a5", ioctl_din); end
    checks++; if (byte_count !== 25'd2) begin errors++; $display("FAIL stall_count got %0d want 2", byte_count); end
  endtask

  task automatic test_out_of_range;
    ioctl_rd = 1'b1; ioctl_addr = 25'h8000; #1;
    checks++; if (ioctl_wait !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL oor_wait_req got %b%b want 00", ioctl_wait, mem_req); end
    step; ioctl_rd = 1'b0; #1;
    checks++; if (ioctl_din !== 8'hFF) begin errors++; $display("FAIL oor_din got %h want ff", ioctl_din); end
    checks++; if (byte_count !== 25'd3 || busy !== 1'b0) begin errors++; $display("FAIL oor_count_busy got %0d/%b want 3/0", byte_count, busy); end
  endtask

  task automatic test_wrong_index;
    ioctl_index = 8'd2; ioctl_rd = 1'b1; ioctl_addr = 25'h10; #1;
    checks++; if (ioctl_wait !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL idx_wait_req got %b%b want 00", ioctl_wait, mem_req); end
    step; ioctl_rd = 1'b0; ioctl_index = 8'd1; #1;
    checks++; if (ioctl_din !== 8'hFF || byte_count !== 25'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL idx_ignored got din=%h cnt=%0d busy=%b want ff/3/0", ioctl_din, byte_count, busy);
    end
  endtask

  task automatic test_back_to_back;
    ioctl_rd = 1'b1; ioctl_addr = 25'h10; #1;
    step; ioctl_rd = 1'b0; #1;
    step; ioctl_rd = 1'b1; ioctl_addr = 25'h20; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_in_lat got busy=%b want 1", busy); end
    step; ioctl_rd = 1'b0; #1;
    checks++; if (ioctl_din !== 8'h5A || byte_count !== 25'd4 || ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL b2b_result got din=%h cnt=%0d wait=%b want 5a/4/0", ioctl_din, byte_count, ioctl_wait);
    end
    step; #1;
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_no_restart got busy=%b req=%b want 0/0", busy, mem_req); end
  endtask

  task automatic test_abort;
    mem_gnt = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h20; #1;
    step; ioctl_rd = 1'b0; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_in_req got %b want 1", mem_req); end
    ioctl_upload = 1'b0;
    step; #1;
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || upload_done !== 1'b1) begin
      errors++; $display("FAIL abort_idle got busy=%b req=%b done=%b want 0/0/1", busy, mem_req, upload_done);
    end
    checks++; if (byte_count !== 25'd4 || ioctl_din !== 8'h5A) begin
      errors++; $display("FAIL abort_held got cnt=%0d din=%h want 4/5a", byte_count, ioctl_din);
    end
    mem_gnt = 1'b1;
    step; #1;
    checks++; if (upload_done !== 1'b0 || busy !== 1'b0 || byte_count !== 25'd4 || ioctl_din !== 8'h5A) begin
      errors++; $display("FAIL abort_after got done=%b busy=%b cnt=%0d din=%h want 0/0/4/5a", upload_done, busy, byte_count, ioctl_din);
    end
  endtask

  task automatic test_reset_lat3;
    int n;
    ioctl_upload = 1'b1; ioctl_index = 8'd1; mem_gnt = 1'b1;
    step;
    ioctl_rd = 1'b1; ioctl_addr = 25'h9000; #1;
    step; ioctl_rd = 1'b0; #1;
    ioctl_rd = 1'b1; ioctl_addr = 25'h10; #1;
    step; ioctl_rd = 1'b0; #1;
    step; #1;
    checks++; if (busy3 !== 1'b1 || byte_count3 !== 25'd1 || ioctl_din3 !== 8'hFF) begin
      errors++; $display("FAIL lat3_pre got busy=%b cnt=%0d din=%h want 1/1/ff", busy3, byte_count3, ioctl_din3);
    end
    #2 reset = 1'b1; #1;
    checks++; if (busy3 !== 1'b0 || mem_req3 !== 1'b0 || ioctl_wait3 !== 1'b0) begin
      errors++; $display("FAIL lat3_reset_ctl got busy=%b req=%b wait=%b want 0/0/0", busy3, mem_req3, ioctl_wait3);
    end
    checks++; if (ioctl_din3 !== 8'h00 || byte_count3 !== 25'd0 || mem_addr3 !== 15'h0) begin
      errors++; $display("FAIL lat3_reset_data got din=%h cnt=%0d addr=%h want 00/0/0", ioctl_din3, byte_count3, mem_addr3);
    end
    step; reset = 1'b0;
    step;
    ioctl_rd = 1'b1; ioctl_addr = 25'h20; #1;
    count_wait(1'b1, n);
    checks++; if (n != 5) begin errors++; $display("FAIL lat3_wait_cycles got %0d want 5", n); end
    checks++; if (ioctl_din3 !== 8'hA5 || byte_count3 !== 25'd1) begin
      errors++; $display("FAIL lat3_serve got din=%h cnt=%0d want a5/1", ioctl_din3, byte_count3);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'hA5;
    test_reset;
    test_basic;
    test_gnt_stall;
    test_out_of_range;
    test_wrong_index;
    test_back_to_back;
    test_abort;
    test_reset_lat3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
